// File: rtl/irq_ctrl.sv
// Interrupt controller for the single-cycle CPU control unit.
// Synchronises and edge-detects the external lines, latches them as pending,
// applies an enable mask, and presents one fixed-priority request at a time
// that must outrank everything currently in service. Bit 0 is the ALU
// overflow trap: it never pends from irq_in and enters only through calli.
module irq_ctrl #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_d,
  input  logic [N_IRQ-1:0] calli,
  input  logic [N_IRQ-1:0] reti,
  output logic [N_IRQ-1:0] min_bit_s,
  output logic [N_IRQ-1:0] min_bit_a,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] mask,
  output logic             irq_active
);

  typedef enum logic {IDLE, PRESENT} state_t;

  localparam logic [N_IRQ-1:0] BIT0 = {{(N_IRQ-1){1'b0}}, 1'b1};

  // Isolates the least-significant set bit (highest priority).
  function automatic logic [N_IRQ-1:0] lowest(input logic [N_IRQ-1:0] v);
    return v & (~v + BIT0);
  endfunction

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] req_vec, req_d;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] cand;
  logic             cand_ok;

  // Synchroniser chain plus one history flop for rising-edge detection.
  // NOTE: the synchroniser array is ordinary flops, not a memory, so it is
  // reset with everything else; a stale 1 would fake an edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Bit 0 can only be raised through calli, so its external line is ignored.
  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q & ~BIT0;

  // Pending latch (new edge wins over a same-cycle acknowledge), mask, and
  // in-service tracking (set before clear, so calli&reti on one bit ends at 0).
  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values of the others, whatever order the statements are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      mask       <= '0;
      in_service <= '0;
    end else begin
      pending    <= (pending & ~ack_clr) | edge_det;
      in_service <= (in_service | calli) & ~reti;
      if (mask_we) mask <= mask_d & ~BIT0;
    end
  end

  // Values derived from registers only, so nothing loops through the CPU.
  assign min_bit_a  = lowest(in_service);
  assign irq_active = |in_service;
  assign cand       = lowest(pending & mask);
  // Both operands are one-hot, so a smaller value means a lower bit index.
  assign cand_ok    = (cand != '0) && ((in_service == '0) || (cand < min_bit_a));

  // Presentation state and the latched request vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_vec <= '0;
    end else begin
      state_q <= state_d;
      req_vec <= req_d;
    end
  end

  // Next-state and outputs: accept a candidate, hold it until acknowledged,
  // or withdraw it if it gets masked while presented.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    req_d     = req_vec;
    ack_clr   = '0;
    min_bit_s = '0;
    unique case (state_q)
      IDLE: begin
        if (cand_ok) begin
          req_d   = cand;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        min_bit_s = req_vec;
        if (calli == req_vec) begin
          ack_clr = req_vec;
          state_d = IDLE;
        end else if ((req_vec & mask) == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller feeding the single-cycle CPU control unit.
- Synchronises and edge-detects external interrupt lines, latches them as pending, and applies an enable mask.
- Arbitrates by fixed priority against the in-service set, which gives nested interrupts, and presents one request vector to the control unit.
- Tracks in-service levels from the control unit's call/return strobes and drives the control unit's min_bit_s / min_bit_a inputs.

Parameters:
- N_IRQ, 8, number of interrupt sources. Bit 0 is reserved for the ALU overflow trap.
- SYNC_STAGES, 2, synchroniser depth on irq_in (2 or 3).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- irq_in  input  N_IRQ  external interrupt lines, asynchronous, rising-edge triggered; bit 0 ignored
- mask_we  input  1  write strobe for the enable mask
- mask_d  input  N_IRQ  mask write data (1 = enabled)
- calli  input  N_IRQ  one-hot vector being entered by the control unit (s_calli), 0 = none
- reti  input  N_IRQ  one-hot level being returned from (s_reti), 0 = none
- min_bit_s  output  N_IRQ  one-hot presented request, 0 = none
- min_bit_a  output  N_IRQ  one-hot lowest set bit of in_service, 0 = none
- pending  output  N_IRQ  latched pending register
- in_service  output  N_IRQ  in-service register
- mask  output  N_IRQ  current enable mask
- irq_active  output  1  OR of in_service

Behaviour:
- Reset (async, any time, including mid-presentation):
  - pending, in_service, mask, req_vec, synchronisers and edge history all go to 0.
  - FSM goes to IDLE; every output reads 0.
- Priority: lower bit index is higher priority. "Lowest bit" means the isolated least-significant set bit.
- Edge capture, per bit i ≥ 1:
  - SYNC_STAGES-flop synchroniser, then a prev flop; edge = sync_out & ~prev.
  - irq_in[i] first sampled high at edge k gives pending[i]=1 after edge k+SYNC_STAGES.
  - A held-high line sets pending once only; it must go low and rise again to re-pend.
- Mask:
  - mask_we loads mask_d with bit 0 forced to 0; new value is effective the next cycle.
  - Masking does not clear pending bits.
- Candidate: lowest bit of (pending & mask), accepted only if its index is strictly lower than the index of min_bit_a, or in_service == 0.
- FSM, 2 states:
  - IDLE: min_bit_s = 0. If a candidate exists, req_vec <= candidate and go to PRESENT; the presentation is 1 cycle after the candidate appears.
  - PRESENT: min_bit_s = req_vec, held stable; a higher-priority arrival does not replace it.
    - If calli == req_vec: clear pending[req_vec], go to IDLE.
    - Else if (req_vec & mask) == 0 (masked while presenting): withdraw to IDLE; pending is kept.
    - Else stay in PRESENT.
- In-service update, every cycle, independent of FSM state:
  - in_service <= (in_service | calli) & ~reti.
  - Any nonzero calli sets its bits, including bit 0 for the overflow trap, which bypasses arbitration.
  - reti bits not currently in service have no effect.
  - calli and reti in the same cycle are both applied; set happens before clear, so the same bit in both ends at 0.
- Set-over-clear on pending: a new edge on bit i in the same cycle that its acknowledge clears pending[i] leaves pending[i]=1.
- min_bit_a and irq_active are combinational from registers only, never from inputs, so there is no loop through the control unit.

Test Plan:
- Reset, then mask_d=8'hFE with mask_we; pulse irq_in[3] high -> pending=8'h08 after SYNC_STAGES edges, min_bit_s=8'h08 one cycle later; calli=8'h08 for 1 cycle -> pending=0, in_service=8'h08, min_bit_a=8'h08, irq_active=1, min_bit_s=0.
- in_service=8'h08, raise irq_in[5] -> pending=8'h20, min_bit_s stays 0; raise irq_in[1] -> min_bit_s=8'h02 (nesting); calli=8'h02 -> in_service=8'h0A, min_bit_a=8'h02; reti=8'h02 -> min_bit_a=8'h08.
- irq_in[2] and irq_in[6] rise in the same cycle, in_service=0 -> min_bit_s=8'h04 first, then after its ack 8'h40 is not presented until in_service drops below bit 6 priority.
- While PRESENT with req_vec=8'h10, write mask=8'hEE -> next cycle FSM in IDLE, min_bit_s=0, pending[4] still 1; restore mask=8'hFE -> 8'h10 re-presented.
- calli=8'h01 (overflow trap) with nothing presented -> in_service=8'h01; reti=8'h01 -> in_service=0; irq_in[0] toggling never sets pending[0].
- Assert reset asynchronously mid-PRESENT with in_service=8'h06 -> all outputs 0 immediately, before the next clk edge.
